// File: rtl/ilog2_pkg.sv
// Shared types and constants for the shared-ilog2 arbiter slice.
package ilog2_pkg;

    localparam int LOG2_W      = 5;
    localparam int OPND_W      = 32;
    localparam int DEF_NUM_REQ = 4;

    // Wide enough for the largest supported lane count (16).
    localparam int MAX_IDX_W   = 4;

    typedef logic [MAX_IDX_W-1:0] lane_idx_t;

    // Stage-1 pipeline word: operand, issuing lane, valid.
    typedef struct packed {
        logic [OPND_W-1:0] v;
        lane_idx_t         idx;
        logic              vld;
    } s1_t;

endpackage

// File: rtl/ilog2.sv
// Combinational integer log2: position of the highest set bit; valid=0 for v==0.
module ilog2 (
    input  logic [31:0] v,
    output logic [4:0]  log2,
    output logic        valid
);

    // Priority encoder, highest set bit wins.
    always_comb begin
        log2 = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                log2 = 5'(i);
            end
        end
    end

    assign valid = |v;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first eligible lane scanning from rr_ptr upward, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    function automatic int wrap(input int a);
        return (a >= NUM_REQ) ? a - NUM_REQ : a;
    endfunction

    // Scan rr_ptr, rr_ptr+1, ... and stop at the first eligible lane.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && elig[wrap(int'(rr_ptr) + k)]) begin
                grant[wrap(int'(rr_ptr) + k)] = 1'b1;
                grant_idx                     = IDX_W'(wrap(int'(rr_ptr) + k));
                any                           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ilog2_arbiter.sv
// Shares one ilog2 unit among NUM_REQ lanes: round-robin accept, 2-stage
// pipeline, per-lane result registers held until the lane consumes them.
module ilog2_arbiter
    import ilog2_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [OPND_W*NUM_REQ-1:0] req_v,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [LOG2_W*NUM_REQ-1:0] rsp_log2,
    output logic [NUM_REQ-1:0]        rsp_zero,
    output logic                      idle
);

    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] hs;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [OPND_W-1:0]  v_sel_p0;
    s1_t                s1_p0;
    s1_t                s1_p1;
    logic [LOG2_W-1:0]  log2_p1;
    logic               nz_p1;

    // A lane with a result outstanding may not issue again until it is consumed.
    assign elig = req_valid & ~busy;
    assign hs   = rsp_valid & rsp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .elig      (elig),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign req_ready = grant;

    // ---- stage 0: select the granted lane's operand ----
    // One-hot grant selects the operand of the accepted lane.
    always_comb begin
        v_sel_p0 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                v_sel_p0 = req_v[OPND_W*i +: OPND_W];
            end
        end
    end

    // Pack the accepted request into the stage-1 word.
    always_comb begin
        s1_p0.v   = v_sel_p0;
        s1_p0.idx = lane_idx_t'(grant_idx);
        s1_p0.vld = grant_any;
    end

    // ---- stage 1: operand register feeding the shared ilog2 ----
    // Reset empties the pipeline so an in-flight request never produces a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_p1 <= '0;
        end else begin
            s1_p1 <= s1_p0;
        end
    end

    ilog2 u_ilog2 (
        .v     (s1_p1.v),
        .log2  (log2_p1),
        .valid (nz_p1)
    );

    // ---- stage 2: write the result into the issuing lane's register ----
    // Results are held stable until the lane handshakes; a write and a
    // handshake never target the same lane because of the busy rule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_log2  <= '0;
            rsp_zero  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (s1_p1.vld && (s1_p1.idx == lane_idx_t'(i))) begin
                    rsp_valid[i]                   <= 1'b1;
                    rsp_log2[LOG2_W*i +: LOG2_W]   <= log2_p1;
                    rsp_zero[i]                    <= ~nz_p1;
                end else if (hs[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Busy spans accept through result consumption.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    busy[i] <= 1'b1;
                end else if (hs[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer moves just past the lane that was granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign idle = ~|busy & ~s1_p1.vld;

endmodule

// File: tb/tb_ilog2_arbiter.sv
// Self-checking bench for ilog2_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_ilog2_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [32*N-1:0] req_v;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [5*N-1:0] rsp_log2;
    logic [N-1:0]   rsp_zero;
    logic           idle;

    int checks = 0;
    int errors = 0;

    ilog2_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_v     (req_v),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_log2  (rsp_log2),
        .rsp_zero  (rsp_zero),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_busy [N];
    bit          m_rv   [N];
    logic [4:0]  m_log2 [N];
    bit          m_zero [N];
    int          m_ptr;
    bit          m_s1_vld;
    int          m_s1_lane;
    logic [31:0] m_s1_v;

    function automatic logic [4:0] ref_log2(input logic [31:0] x);
        int n = 0;
        logic [31:0] t = x;
        while (t > 1) begin
            t = t >> 1;
            n++;
        end
        return 5'(n);
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int l;
            l = (m_ptr + k) % N;
            if (req_valid[l] && !m_busy[l]) return l;
        end
        return -1;
    endfunction

    function automatic logic [31:0] lane_v(input int l);
        if (l < 0) return 32'h0;
        return req_v[32*l +: 32];
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = model_grant();
        return (g < 0) ? '0 : N'(1 << g);
    endfunction

    function automatic logic [N-1:0] exp_rv();
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = m_rv[i];
        return r;
    endfunction

    function automatic logic exp_idle();
        for (int i = 0; i < N; i++) if (m_busy[i]) return 1'b0;
        return !m_s1_vld;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] <= 1'b0;
                m_rv[i]   <= 1'b0;
                m_log2[i] <= 5'd0;
                m_zero[i] <= 1'b0;
            end
            m_ptr     <= 0;
            m_s1_vld  <= 1'b0;
            m_s1_lane <= 0;
            m_s1_v    <= 32'h0;
        end else begin
            if (model_grant() >= 0) m_ptr <= (model_grant() + 1) % N;
            m_s1_vld  <= (model_grant() >= 0);
            m_s1_lane <= model_grant();
            m_s1_v    <= lane_v(model_grant());
            for (int i = 0; i < N; i++) begin
                if (model_grant() == i) m_busy[i] <= 1'b1;
                else if (m_rv[i] && rsp_ready[i]) m_busy[i] <= 1'b0;
                if (m_s1_vld && m_s1_lane == i) begin
                    m_rv[i]   <= 1'b1;
                    m_log2[i] <= ref_log2(m_s1_v);
                    m_zero[i] <= (m_s1_v == 32'h0);
                end else if (m_rv[i] && rsp_ready[i]) begin
                    m_rv[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_v     = '0;
        rsp_ready = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        #1;
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_log2 !== '0) begin errors++; $display("FAIL reset_rsp_log2 got=%h want=0", rsp_log2); end
        checks++; if (rsp_zero !== '0) begin errors++; $display("FAIL reset_rsp_zero got=%b want=0", rsp_zero); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b want=1", idle); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        rsp_ready = 4'hF;
        req_v = '0;
        req_v[31:0] = 32'h0000_0001;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b want=0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 4'b0000 || idle !== 1'b0) begin errors++; $display("FAIL single_latency1 rsp_valid=%b idle=%b want 0000/0", rsp_valid, idle); end
        tick();
        #1;
        checks++; if (rsp_valid !== 4'b0001 || rsp_log2[4:0] !== 5'd0 || rsp_zero[0] !== 1'b0)
            begin errors++; $display("FAIL single_result valid=%b log2=%0d zero=%b want 0001/0/0", rsp_valid, rsp_log2[4:0], rsp_zero[0]); end
        tick();
        #1;
        checks++; if (rsp_valid !== 4'b0000 || idle !== 1'b1) begin errors++; $display("FAIL single_drain valid=%b idle=%b want 0000/1", rsp_valid, idle); end
    endtask

    task automatic test_zero();
        rsp_ready = 4'hF;
        req_v = '0;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_grant got=%b want=0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
        #1;
        checks++; if (rsp_valid !== 4'b0010 || rsp_log2[9:5] !== 5'd0 || rsp_zero[1] !== 1'b1)
            begin errors++; $display("FAIL zero_result valid=%b log2=%0d zero=%b want 0010/0/1", rsp_valid, rsp_log2[9:5], rsp_zero[1]); end
        tick();
    endtask

    task automatic test_all_lanes();
        int exp_l [4] = '{31, 16, 8, 7};
        apply_reset();
        rsp_ready = '0;
        req_v = {32'h0000_00FF, 32'h0000_0100, 32'h0001_0000, 32'h8000_0000};
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << k)) begin errors++; $display("FAIL all_grant%0d got=%b want=%b", k, req_ready, 4'(1 << k)); end
            tick();
            req_valid[k] = 1'b0;
        end
        tick();
        tick();
        #1;
        checks++; if (rsp_valid !== 4'hF) begin errors++; $display("FAIL all_valid got=%b want=1111", rsp_valid); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rsp_log2[5*k +: 5] !== 5'(exp_l[k]) || rsp_zero[k] !== 1'b0)
                begin errors++; $display("FAIL all_log2_%0d got=%0d zero=%b want=%0d/0", k, rsp_log2[5*k +: 5], rsp_zero[k], exp_l[k]); end
        end
        rsp_ready = 4'hF;
        tick();
        #1;
        checks++; if (rsp_valid !== 4'h0 || idle !== 1'b1) begin errors++; $display("FAIL all_drain valid=%b idle=%b want 0000/1", rsp_valid, idle); end
    endtask

    task automatic test_hold();
        rsp_ready = 4'b1101;
        req_v = '0;
        req_v[63:32] = 32'h0000_0400;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_grant got=%b want=0010", req_ready); end
        tick();
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_busy got=%b want=0000", req_ready); end
        tick();
        #1;
        checks++; if (rsp_valid[1] !== 1'b1 || rsp_log2[9:5] !== 5'd10) begin errors++; $display("FAIL hold_first valid=%b log2=%0d want 1/10", rsp_valid[1], rsp_log2[9:5]); end
        req_v[63:32] = 32'h0000_FFFF;
        for (int c = 0; c < 10; c++) begin
            tick();
            #1;
            checks++; if ({req_ready[1], rsp_valid[1], rsp_log2[9:5], rsp_zero[1]} !== {1'b0, 1'b1, 5'd10, 1'b0})
                begin errors++; $display("FAIL hold_stable%0d ready=%b valid=%b log2=%0d zero=%b want 0/1/10/0", c, req_ready[1], rsp_valid[1], rsp_log2[9:5], rsp_zero[1]); end
        end
        rsp_ready[1] = 1'b1;
        #1;
        checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL hold_pulse_ready got=%b want=0", req_ready[1]); end
        tick();
        rsp_ready[1] = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010 || rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL hold_reaccept ready=%b valid=%b want 0010/0", req_ready, rsp_valid[1]); end
        tick();
        req_valid = '0;
        tick();
        #1;
        checks++; if (rsp_valid[1] !== 1'b1 || rsp_log2[9:5] !== 5'd15) begin errors++; $display("FAIL hold_second valid=%b log2=%0d want 1/15", rsp_valid[1], rsp_log2[9:5]); end
        rsp_ready = 4'hF;
        tick();
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL hold_idle got=%b want=1", idle); end
    endtask

    task automatic test_alternate();
        logic [31:0] v0;
        logic [3:0]  want_rdy;
        logic [3:0]  want_rv;
        apply_reset();
        rsp_ready = 4'hF;
        v0 = $urandom | 32'h1;
        req_v = '0;
        req_v[31:0]  = v0;
        req_v[95:64] = $urandom;
        req_valid = 4'b0101;
        for (int c = 0; c < 12; c++) begin
            want_rdy = (c % 3 == 0) ? 4'b0001 : (c % 3 == 1) ? 4'b0100 : 4'b0000;
            want_rv  = (c % 3 == 2) ? 4'b0001 : (c % 3 == 0 && c > 0) ? 4'b0100 : 4'b0000;
            #1;
            checks++; if (req_ready !== want_rdy || rsp_valid !== want_rv)
                begin errors++; $display("FAIL alt_cycle%0d ready=%b valid=%b want %b/%b", c, req_ready, rsp_valid, want_rdy, want_rv); end
            if (c % 3 == 2) begin
                checks++; if (rsp_log2[4:0] !== ref_log2(v0)) begin errors++; $display("FAIL alt_log2_%0d got=%0d want=%0d", c, rsp_log2[4:0], ref_log2(v0)); end
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_inflight();
        apply_reset();
        rsp_ready = 4'b1101;
        req_v = '0;
        req_v[63:32] = 32'h0000_1000;
        req_valid = 4'b0010;
        tick();
        req_v[95:64] = 32'h0000_0005;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rstf_grant got=%b want=0100", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 4'b0010 || rsp_log2[9:5] !== 5'd12) begin errors++; $display("FAIL rstf_pre valid=%b log2=%0d want 0010/12", rsp_valid, rsp_log2[9:5]); end
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== '0 || rsp_log2 !== '0 || rsp_zero !== '0 || idle !== 1'b1)
            begin errors++; $display("FAIL rstf_async valid=%b log2=%h zero=%b idle=%b want 0/0/0/1", rsp_valid, rsp_log2, rsp_zero, idle); end
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (rsp_valid !== '0 || idle !== 1'b1) begin errors++; $display("FAIL rstf_after%0d valid=%b idle=%b want 0000/1", c, rsp_valid, idle); end
            tick();
        end
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstf_ptr got=%b want=0001", req_ready); end
        tick();
        req_valid = '0;
        rsp_ready = 4'hF;
        tick();
        tick();
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            rsp_ready = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: req_v[32*i +: 32] = 32'h0;
                    1: req_v[32*i +: 32] = 32'h1 << $urandom_range(0, 31);
                    2: req_v[32*i +: 32] = $urandom;
                    default: req_v[32*i +: 32] = 32'($urandom_range(0, 255));
                endcase
            end
            #1;
            checks++; if (req_ready !== exp_ready() || rsp_valid !== exp_rv() || idle !== exp_idle())
                begin errors++; $display("FAIL rand%0d ready=%b/%b valid=%b/%b idle=%b/%b (got/want)", c, req_ready, exp_ready(), rsp_valid, exp_rv(), idle, exp_idle()); end
            for (int i = 0; i < N; i++) begin
                if (m_rv[i]) begin
                    checks++; if (rsp_log2[5*i +: 5] !== m_log2[i] || rsp_zero[i] !== m_zero[i])
                        begin errors++; $display("FAIL rand%0d_lane%0d log2=%0d zero=%b want %0d/%b", c, i, rsp_log2[5*i +: 5], rsp_zero[i], m_log2[i], m_zero[i]); end
                end
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = 4'hF;
        for (int c = 0; c < 4; c++) tick();
        #1;
        checks++; if (idle !== 1'b1 || rsp_valid !== '0) begin errors++; $display("FAIL rand_drain idle=%b valid=%b want 1/0000", idle, rsp_valid); end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_v     = '0;
        rsp_ready = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_zero();
        test_all_lanes();
        test_hold();
        test_alternate();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
